// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
//   ADDR_W/DATA_W : register index and data widths of the 32x32 register file
//   NUM_REQ       : number of writeback sources
//   SRC_*         : source slot indices on the request vectors
package regfile_wb_arbiter_pkg;

  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NUM_REQ = 3;

  localparam int unsigned SRC_ALU = 0;
  localparam int unsigned SRC_MD  = 1;
  localparam int unsigned SRC_MEM = 2;

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin arbiter: grants the first valid source at or above rr_ptr,
// wrapping at NUM_REQ-1, and moves the pointer past the winner on a transfer.
//   clock, ctrl_reset : clock, async active-low reset
//   valid             : per-source request
//   advance           : a granted request was accepted this cycle
//   grant             : one-hot grant (0 when nothing is valid)
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic               clock,
  input  logic               ctrl_reset,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] idx;
  logic             found;
  int unsigned      idx_wide;

  // Search from rr_ptr upward with wrap; first valid wins.
  always_comb begin
    grant     = '0;
    grant_idx = rr_ptr;
    found     = 1'b0;
    idx       = '0;
    idx_wide  = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx_wide = 32'(rr_ptr) + k;
      if (idx_wide >= NUM_REQ) idx_wide = idx_wide - NUM_REQ;
      idx = PTR_W'(idx_wide);
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  // Pointer moves to one past the winner only when a transfer happens.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port among the ALU, multdiv and load
// writeback sources, registers the winning write, and tracks registers with
// outstanding long-latency producers to raise decode stalls and bypasses.
//   clock, ctrl_reset          : clock, async active-low reset
//   req_valid/req_ready        : per-source handshake
//   req_reg/req_data           : per-source destination and data (packed slots)
//   issue_valid/issue_reg      : mark a destination pending at issue
//   flush                      : clear scoreboard and write stage
//   ctrl_readRegA/B            : decode read indices
//   ctrl_writeEnable/WriteReg,
//   data_writeReg              : register file write port
//   stall, bypass_a, bypass_b  : hazard indications toward decode
//   pending_mask               : scoreboard contents
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = regfile_wb_arbiter_pkg::NUM_REQ,
  parameter int unsigned DATA_W  = regfile_wb_arbiter_pkg::DATA_W,
  parameter int unsigned ADDR_W  = regfile_wb_arbiter_pkg::ADDR_W
) (
  input  logic                      clock,
  input  logic                      ctrl_reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_reg,
  input  logic                      flush,
  input  logic [ADDR_W-1:0]         ctrl_readRegA,
  input  logic [ADDR_W-1:0]         ctrl_readRegB,
  output logic                      ctrl_writeEnable,
  output logic [ADDR_W-1:0]         ctrl_writeReg,
  output logic [DATA_W-1:0]         data_writeReg,
  output logic                      stall,
  output logic                      bypass_a,
  output logic                      bypass_b,
  output logic [(1<<ADDR_W)-1:0]    pending_mask
);

  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  logic [NUM_REQ-1:0]  grant_c;
  logic                accept_en_c;
  logic                transfer_c;
  logic [ADDR_W-1:0]   sel_reg_c;
  logic [DATA_W-1:0]   sel_data_c;
  logic [NUM_REGS-1:0] pending_next_c;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .clock      (clock),
    .ctrl_reset (ctrl_reset),
    .valid      (req_valid),
    .advance    (transfer_c),
    .grant      (grant_c)
  );

  // No handshake completes while in reset or during a flush cycle.
  assign accept_en_c = ctrl_reset & ~flush;
  assign req_ready   = grant_c & {NUM_REQ{accept_en_c}};
  assign transfer_c  = |(req_valid & req_ready);

  // Select the accepted source's payload.
  always_comb begin
    sel_reg_c  = '0;
    sel_data_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_reg_c  = req_reg[i*ADDR_W +: ADDR_W];
        sel_data_c = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Write stage: one-cycle latency, drained every cycle; r0 writes are swallowed.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
    end else if (flush) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
    end else if (transfer_c) begin
      ctrl_writeEnable <= (sel_reg_c != '0);
      ctrl_writeReg    <= sel_reg_c;
      data_writeReg    <= sel_data_c;
    end else begin
      ctrl_writeEnable <= 1'b0;
    end
  end

  // Scoreboard: retire on write, set on issue; a same-cycle issue wins.
  always_comb begin
    pending_next_c = pending_mask;
    if (ctrl_writeEnable) pending_next_c[ctrl_writeReg] = 1'b0;
    if (issue_valid && (issue_reg != '0)) pending_next_c[issue_reg] = 1'b1;
    pending_next_c[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      pending_mask <= '0;
    end else if (flush) begin
      pending_mask <= '0;
    end else begin
      pending_mask <= pending_next_c;
    end
  end

  // Hazards toward decode; r0 never stalls or bypasses.
  assign stall    = ((ctrl_readRegA != '0) & pending_mask[ctrl_readRegA]) |
                    ((ctrl_readRegB != '0) & pending_mask[ctrl_readRegB]);
  assign bypass_a = ctrl_writeEnable & (ctrl_writeReg == ctrl_readRegA) & (ctrl_readRegA != '0);
  assign bypass_b = ctrl_writeEnable & (ctrl_writeReg == ctrl_readRegB) & (ctrl_readRegB != '0);

endmodule
